// File: rtl/conv_row_scheduler.sv
// Row/word sequencer for the 3-buffer / 3-slab BRAM handler of the 3x3 conv datapath.
// Optional zero padding of the first/last output row is enabled with `define CONV_SCHED_PAD_EN.

module conv_row_lane #(
  parameter int ADR_W = 16,
  parameter int ROW_K = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             active_i,
  input  logic             adv_i,
  input  logic             clr_i,
  input  logic             pad_i,
  input  logic [1:0]       rot_i,
  input  logic [ADR_W-1:0] col_i,
  output logic [ADR_W-1:0] adr_o,
  output logic [1:0]       idx_o,
  output logic [1:0]       last_idx_o,
  output logic             valid_o
);
  logic [2:0] sum;
  logic [1:0] idx_raw;
  logic [1:0] last_q;

  // ((rot + K - 1) mod 3) + 1 without a divider; sum is at most 4
  assign sum     = {1'b0, rot_i} + 3'(ROW_K - 1);
  assign idx_raw = (sum >= 3'd3) ? 2'(sum - 3'd2) : 2'(sum + 3'd1);

  assign idx_o   = (active_i && !pad_i) ? idx_raw : 2'd0;
  assign valid_o = adv_i && !pad_i;
  assign adr_o   = active_i ? col_i : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   last_q <= 2'd0;
    else if (clr_i) last_q <= 2'd0;
    else if (adv_i) last_q <= idx_o;
  end

  assign last_idx_o = last_q;
endmodule

module conv_row_scheduler #(
  parameter int PIXELS_IN_ROW = 32,
  parameter int ADR_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             en_i,
  input  logic [ADR_W-1:0] cfg_row_words_i,
  input  logic [ADR_W-1:0] cfg_out_rows_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ADR_W-1:0] cur_row_o,
  output logic [ADR_W-1:0] row1_buf_adr_o,
  output logic [ADR_W-1:0] row2_buf_adr_o,
  output logic [ADR_W-1:0] row3_buf_adr_o,
  output logic [ADR_W-1:0] row1_slab_adr_o,
  output logic [ADR_W-1:0] row2_slab_adr_o,
  output logic [ADR_W-1:0] row3_slab_adr_o,
  output logic [1:0]       row1_buf_idx_o,
  output logic [1:0]       row2_buf_idx_o,
  output logic [1:0]       row3_buf_idx_o,
  output logic [1:0]       row1_slab_idx_o,
  output logic [1:0]       row2_slab_idx_o,
  output logic [1:0]       row3_slab_idx_o,
  output logic [1:0]       last_row1_buf_idx_o,
  output logic [1:0]       last_row2_buf_idx_o,
  output logic [1:0]       last_row3_buf_idx_o,
  output logic [1:0]       last_row1_slab_idx_o,
  output logic [1:0]       last_row2_slab_idx_o,
  output logic [1:0]       last_row3_slab_idx_o,
  output logic             valid_row1_adr_o,
  output logic             valid_row2_adr_o,
  output logic             valid_row3_adr_o
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [ADR_W-1:0] col_q, col_d;
  logic [ADR_W-1:0] row_q, row_d;
  logic [ADR_W-1:0] words_q, words_d;
  logic [ADR_W-1:0] rows_q, rows_d;
  logic [1:0]       rot_q, rot_d;

  logic                       active, adv, clr;
  logic [2:0]                 pad;
  logic [2:0][ADR_W-1:0]      adr;
  logic [2:0][1:0]            idx, last_idx;
  logic [2:0]                 vld;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      words_q <= '0;
      rows_q  <= '0;
      rot_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      words_q <= words_d;
      rows_q  <= rows_d;
      rot_q   <= rot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    words_d = words_q;
    rows_d  = rows_q;
    rot_d   = rot_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          words_d = cfg_row_words_i;
          rows_d  = cfg_out_rows_i;
          col_d   = '0;
          row_d   = '0;
          rot_d   = 2'd0;
          state_d = (cfg_row_words_i == '0 || cfg_out_rows_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (en_i) begin
          if (col_q == words_q - ADR_W'(1)) begin
            col_d = '0;
            if (row_q == rows_q - ADR_W'(1)) begin
              state_d = S_DONE;
            end else begin
              row_d = row_q + ADR_W'(1);
              // oldest buffer becomes the newest row
              rot_d = (rot_q == 2'd2) ? 2'd0 : rot_q + 2'd1;
            end
          end else begin
            col_d = col_q + ADR_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign active = (state_q == S_RUN);
  assign adv    = active && en_i;
  assign clr    = (state_q == S_DONE);

`ifdef CONV_SCHED_PAD_EN
  assign pad = {row_q == rows_q - ADR_W'(1), 1'b0, row_q == '0};
`else
  assign pad = 3'b000;
`endif

  for (genvar k = 0; k < 3; k++) begin : g_row
    conv_row_lane #(.ADR_W(ADR_W), .ROW_K(k + 1)) u_lane (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .active_i   (active),
      .adv_i      (adv),
      .clr_i      (clr),
      .pad_i      (pad[k]),
      .rot_i      (rot_q),
      .col_i      (col_q),
      .adr_o      (adr[k]),
      .idx_o      (idx[k]),
      .last_idx_o (last_idx[k]),
      .valid_o    (vld[k])
    );
  end

  assign busy_o    = active;
  assign done_o    = (state_q == S_DONE);
  assign cur_row_o = active ? row_q : '0;

  assign row1_buf_adr_o  = adr[0];
  assign row2_buf_adr_o  = adr[1];
  assign row3_buf_adr_o  = adr[2];
  assign row1_slab_adr_o = adr[0];
  assign row2_slab_adr_o = adr[1];
  assign row3_slab_adr_o = adr[2];

  assign row1_buf_idx_o  = idx[0];
  assign row2_buf_idx_o  = idx[1];
  assign row3_buf_idx_o  = idx[2];
  assign row1_slab_idx_o = idx[0];
  assign row2_slab_idx_o = idx[1];
  assign row3_slab_idx_o = idx[2];

  assign last_row1_buf_idx_o  = last_idx[0];
  assign last_row2_buf_idx_o  = last_idx[1];
  assign last_row3_buf_idx_o  = last_idx[2];
  assign last_row1_slab_idx_o = last_idx[0];
  assign last_row2_slab_idx_o = last_idx[1];
  assign last_row3_slab_idx_o = last_idx[2];

  assign valid_row1_adr_o = vld[0];
  assign valid_row2_adr_o = vld[1];
  assign valid_row3_adr_o = vld[2];
endmodule

// File: tb/tb_conv_row_scheduler.sv
// Self-checking bench for conv_row_scheduler against a row/column walk model.
module tb_conv_row_scheduler;
  localparam int ADR_W = 16;

  logic clk, rst_n, start, en;
  logic [ADR_W-1:0] cfg_w, cfg_r;
  logic busy, done;
  logic [ADR_W-1:0] cur_row, b1, b2, b3, s1, s2, s3;
  logic [1:0] bi1, bi2, bi3, si1, si2, si3, lb1, lb2, lb3, ls1, ls2, ls3;
  logic v1, v2, v3;
  logic [140:0] obs;

  int n_chk = 0;
  int n_fail = 0;
  int m_rows = 1;

  conv_row_scheduler #(.PIXELS_IN_ROW(32), .ADR_W(ADR_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .en_i(en),
    .cfg_row_words_i(cfg_w), .cfg_out_rows_i(cfg_r),
    .busy_o(busy), .done_o(done), .cur_row_o(cur_row),
    .row1_buf_adr_o(b1), .row2_buf_adr_o(b2), .row3_buf_adr_o(b3),
    .row1_slab_adr_o(s1), .row2_slab_adr_o(s2), .row3_slab_adr_o(s3),
    .row1_buf_idx_o(bi1), .row2_buf_idx_o(bi2), .row3_buf_idx_o(bi3),
    .row1_slab_idx_o(si1), .row2_slab_idx_o(si2), .row3_slab_idx_o(si3),
    .last_row1_buf_idx_o(lb1), .last_row2_buf_idx_o(lb2), .last_row3_buf_idx_o(lb3),
    .last_row1_slab_idx_o(ls1), .last_row2_slab_idx_o(ls2), .last_row3_slab_idx_o(ls3),
    .valid_row1_adr_o(v1), .valid_row2_adr_o(v2), .valid_row3_adr_o(v3)
  );

  assign obs = {busy, done, cur_row, b1, b2, b3, s1, s2, s3, bi1, bi2, bi3, si1, si2, si3,
                lb1, lb2, lb3, ls1, ls2, ls3, v1, v2, v3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer used by window row k of output row r: rows rotate one buffer per output row.
  function automatic logic [1:0] midx(input int r, input int k);
`ifdef CONV_SCHED_PAD_EN
    if (k == 1 && r == 0) return 2'd0;
    if (k == 3 && r == m_rows - 1) return 2'd0;
`endif
    return 2'(((r + k - 1) % 3) + 1);
  endfunction

  function automatic logic [140:0] mk(input logic bsy, input logic dn, input int r, input int c,
                                      input logic act, input logic en_now,
                                      input logic [1:0] l1, input logic [1:0] l2, input logic [1:0] l3);
    logic [1:0] i1, i2, i3;
    logic [15:0] a, cr;
    logic e1, e2, e3;
    i1 = act ? midx(r, 1) : 2'd0;
    i2 = act ? midx(r, 2) : 2'd0;
    i3 = act ? midx(r, 3) : 2'd0;
    a  = act ? 16'(c) : 16'd0;
    cr = act ? 16'(r) : 16'd0;
    e1 = act && en_now && (i1 != 2'd0);
    e2 = act && en_now && (i2 != 2'd0);
    e3 = act && en_now && (i3 != 2'd0);
    return {bsy, dn, cr, a, a, a, a, a, a, i1, i2, i3, i1, i2, i3, l1, l2, l3, l1, l2, l3, e1, e2, e3};
  endfunction

  // mode 0: en always 1; mode 1: en toggles 1,0,...; mode 2: random en plus ignored start pulses
  task automatic run_job(input int words, input int rows, input int mode, input string nm);
    int r, c, issued, cyc, total;
    logic [1:0] l1, l2, l3;
    logic e;
    logic [140:0] ex;
    m_rows = rows;
    total = words * rows;
    @(negedge clk);
    start = 1'b1; cfg_w = ADR_W'(words); cfg_r = ADR_W'(rows); en = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    r = 0; c = 0; issued = 0; cyc = 0; l1 = 2'd0; l2 = 2'd0; l3 = 2'd0;
    while (issued < total && cyc < 4000) begin
      e = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      en = e;
      if (mode == 2) begin
        start = 1'($urandom_range(0, 1));
        cfg_w = ADR_W'($urandom);
        cfg_r = ADR_W'($urandom);
      end
      #1;
      ex = mk(1'b1, 1'b0, r, c, 1'b1, e, l1, l2, l3);
      n_chk++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL %s run r=%0d c=%0d: got %h want %h", nm, r, c, obs, ex);
      end
      if (e) begin
        l1 = midx(r, 1); l2 = midx(r, 2); l3 = midx(r, 3);
        issued++;
        c++;
        if (c == words) begin
          c = 0;
          r++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    if (issued < total) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: issued %0d want %0d", nm, issued, total);
    end
    start = (mode == 2);
    en = 1'($urandom_range(0, 1));
    #1;
    ex = mk(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, l1, l2, l3);
    n_chk++;
    if (obs !== ex) begin
      n_fail++;
      $display("FAIL %s done: got %h want %h", nm, obs, ex);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL %s idle_after: got %h want 0", nm, obs);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; en = 1'b0; cfg_w = '0; cfg_r = '0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want 0", obs);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_chk++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_idle%0d: got %h want 0", i, obs);
      end
    end
  endtask

  task automatic test_basic();
    run_job(4, 2, 0, "basic");
  endtask

  task automatic test_en_toggle();
    run_job(4, 2, 1, "en_toggle");
  endtask

  task automatic test_rotation();
    run_job(3, 4, 0, "rotation");
  endtask

  task automatic test_zero_cfg();
    int w[2] = '{0, 5};
    int h[2] = '{3, 0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b1; en = 1'b1; cfg_w = ADR_W'(w[i]); cfg_r = ADR_W'(h[i]);
      @(negedge clk);
      start = 1'b0;
      #1;
      n_chk++;
      if (obs !== mk(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0)) begin
        n_fail++;
        $display("FAIL zero_cfg%0d done: got %h", i, obs);
      end
      @(negedge clk);
      #1;
      n_chk++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL zero_cfg%0d idle: got %h want 0", i, obs);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [140:0] ex;
    m_rows = 2;
    @(negedge clk);
    start = 1'b1; en = 1'b1; cfg_w = 16'd4; cfg_r = 16'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    ex = mk(1'b1, 1'b0, 1, 3, 1'b1, 1'b1, midx(1, 1), midx(1, 2), midx(1, 3));
    n_chk++;
    if (obs !== ex) begin
      n_fail++;
      $display("FAIL midrun_pos: got %h want %h", obs, ex);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got %h want 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    run_job(4, 2, 0, "restart");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_job(int'($urandom_range(1, 6)), int'($urandom_range(1, 5)), 2, "random");
  endtask

`ifdef CONV_SCHED_PAD_EN
  task automatic test_pad();
    run_job(4, 3, 0, "pad3");
    run_job(3, 1, 0, "pad1");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_en_toggle();
    test_rotation();
    test_zero_cfg();
    test_reset_mid_run();
    test_random();
`ifdef CONV_SCHED_PAD_EN
    test_pad();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
